// File: rtl/inst_queue_if.sv
// Decoded-instruction payload type and the decoder/dispatcher handshake
// interface of the instruction queue.
//   decoded_pack_in / in_valid / in_ready : decoder -> queue enqueue side
//   almost_full                           : occupancy throttle for fetch/decode
//   decoded_pack_out / out_valid          : head entry presented to the dispatcher
//   dispatch_stall                        : dispatcher does not consume the head
//   flush                                 : squash every buffered entry
//   count                                 : current occupancy, 0..DEPTH
package inst_queue_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    // One decoded instruction as produced by the decoder.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic               is_halt;
    } decoded_pack_t;

endpackage

interface inst_queue_if #(
    parameter int unsigned DEPTH = 8
) ();
    import inst_queue_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    decoded_pack_t      decoded_pack_in;
    logic               in_valid;
    logic               in_ready;
    logic               almost_full;
    decoded_pack_t      decoded_pack_out;
    logic               out_valid;
    logic               dispatch_stall;
    logic               flush;
    logic [CNT_W-1:0]   count;

    // Decoder/dispatcher/control side.
    modport master (
        output decoded_pack_in,
        output in_valid,
        input  in_ready,
        input  almost_full,
        input  decoded_pack_out,
        input  out_valid,
        output dispatch_stall,
        output flush,
        input  count
    );

    // Queue side.
    modport slave (
        input  decoded_pack_in,
        input  in_valid,
        output in_ready,
        output almost_full,
        output decoded_pack_out,
        output out_valid,
        input  dispatch_stall,
        input  flush,
        output count
    );

endinterface

// File: rtl/inst_queue.sv
// In-order first-word-fall-through instruction queue between decoder and
// dispatcher. The oldest entry is presented combinationally so the
// dispatcher can consume it in the same cycle; a flush discards everything.
// Ports:
//   clk    : system clock, all state updates on posedge
//   reset  : synchronous active-low reset
//   q_if   : inst_queue_if.slave handshake bundle (see interface header)
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic          clk,
    input  logic          reset,
    inst_queue_if.slave   q_if
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Pointer wrap relies on natural modulo-2^PTR_W arithmetic.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("inst_queue: DEPTH must be a power of 2 and at least 2");
    end

    decoded_pack_t      mem_q [DEPTH];
    decoded_pack_t      mem_d [DEPTH];
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0]   tail_ptr_q, tail_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    logic               empty;
    logic               full;
    logic               enq;
    logic               deq;

    // Status derived from registered state only.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
    end

    // Handshake fires; flush squashes both sides of the cycle.
    always_comb begin
        enq = q_if.in_valid & ~full & ~q_if.flush;
        deq = ~empty & ~q_if.dispatch_stall & ~q_if.flush;
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;

        if (enq) begin
            mem_d[tail_ptr_q] = q_if.decoded_pack_in;
            tail_ptr_d        = tail_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            head_ptr_d = head_ptr_q + PTR_W'(1);
        end

        // Simultaneous enq and deq leave the occupancy unchanged.
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
        end

        if (q_if.flush) begin
            head_ptr_d = '0;
            tail_ptr_d = '0;
            count_d    = '0;
        end
    end

    // Control state; reset wins over flush and any transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: empty slots are never forwarded.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs; an empty queue shows an all-zero no-op pack, never stale data.
    always_comb begin
        q_if.in_ready         = ~full;
        q_if.out_valid        = ~empty;
        q_if.almost_full      = (count_q >= CNT_W'(AF_LEVEL));
        q_if.count            = count_q;
        q_if.decoded_pack_out = '0;
        if (!empty) begin
            q_if.decoded_pack_out = mem_q[head_ptr_q];
        end
    end

    // Occupancy and pointer consistency invariants.
    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        count_q <= CNT_W'(DEPTH));
    a_no_enq_full : assert property (@(posedge clk) disable iff (!reset)
        !(enq && full));
    a_no_deq_empty : assert property (@(posedge clk) disable iff (!reset)
        !(deq && empty));
    // Full occupancy has equal pointers and a zero low count field.
    a_ptr_count : assert property (@(posedge clk) disable iff (!reset)
        PTR_W'(tail_ptr_q - head_ptr_q) == count_q[PTR_W-1:0]);

endmodule
